int_res_mem_ctrl: RTL and testbench

- Parametrised access controller between the compute datapath and the intermediate-result (int-res) CIM SRAM banks.
- Accepts logical word-address requests in single or double width. Maps each request to a bank and a bank word.
- Converts fixed-point values between the compute format (N_COMP bits, Q_COMP fractional bits) and the storage formats.
- Generalises the fixed 4-bank, 15-bit map to any bank count, depth and storage width, and adds bank-straddling double-width accesses with saturation on write.

---
 rtl/int_res_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_int_res_mem_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/int_res_mem_ctrl.sv
// int_res_mem_ctrl: int-res SRAM bank controller with format conversion; INT_RES_MEM_SAT_STATS_EN enables sat_count
module int_res_mem_ctrl #(
  parameter int N_BANKS    = 4,
  parameter int BANK_DEPTH = 14336,
  parameter int N_STO      = 15,
  parameter int N_COMP     = 39,
  parameter int Q_COMP     = 21
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [$clog2(N_BANKS*BANK_DEPTH)-1:0] req_addr,
  input  logic                                  req_width,
  input  logic [2:0]                            req_format,
  input  logic [N_COMP-1:0]                     req_wdata,
  output logic                                  rsp_valid,
  output logic [N_COMP-1:0]                     rsp_rdata,
  output logic                                  rsp_err,
  output logic [N_BANKS-1:0]                    bank_en,
  output logic                                  bank_wen,
  output logic [$clog2(BANK_DEPTH)-1:0]         bank_addr,
  output logic [N_STO-1:0]                      bank_wdata,
  input  logic [N_BANKS*N_STO-1:0]              bank_rdata,
  output logic [15:0]                           sat_count
);
  localparam int AW  = $clog2(N_BANKS*BANK_DEPTH);
  localparam int BW  = $clog2(BANK_DEPTH);
  localparam int BIW = N_BANKS > 1 ? $clog2(N_BANKS) : 1;
  localparam int SW  = 2*N_STO;
  localparam int SHW = $clog2(N_COMP+1);
  localparam logic [AW:0] TOTAL = (AW+1)'(N_BANKS*BANK_DEPTH);

  typedef enum logic [2:0] {IDLE, ACC_HI, ACC_LO, WAIT, RESP} state_t;
  state_t state, nxt;

  logic              r_write, r_dbl;
  logic [AW-1:0]     r_addr;
  logic [2:0]        r_fmt;
  logic [N_COMP-1:0] r_wdata;
  logic [N_STO-1:0]  rd_hi, rd_lo;
  logic              acc, err, ovf, unf;
  logic [AW:0]       a0, a1;
  logic [BIW-1:0]    b_hi, b_lo;
  logic [BW-1:0]     w_hi, w_lo;
  int                f;
  logic [SHW-1:0]    sh;
  logic signed [N_COMP+1:0] h;
  logic signed [N_COMP:0]   rnd, max_v, min_v;
  logic [SW-1:0]     st;
  logic [N_COMP-1:0] rx, rdata_c;

  // comparator chain instead of a divider: last bank whose base is <= a wins
  function automatic logic [BIW+BW-1:0] map(input logic [AW:0] a);
    logic [BIW-1:0] b;
    logic [BW-1:0]  w;
    b = '0;
    w = BW'(a);
    for (int i = 1; i < N_BANKS; i++)
      if (a >= (AW+1)'(i*BANK_DEPTH)) begin
        b = BIW'(i);
        w = BW'(a - (AW+1)'(i*BANK_DEPTH));
      end
    return {b, w};
  endfunction

  assign a0 = {1'b0, r_addr};
  assign a1 = a0 + 1'b1;
  assign {b_hi, w_hi} = map(a0);
  assign {b_lo, w_lo} = map(a1);
  assign err = a0 >= TOTAL || (r_dbl && a1 >= TOTAL);

  assign req_ready = state == IDLE || state == RESP;
  assign acc       = req_valid && req_ready;
  assign rsp_valid = state == RESP;
  assign rsp_err   = rsp_valid && err;
  assign rsp_rdata = rsp_valid && !err && !r_write ? rdata_c : '0;

  always_comb begin
    nxt = state == IDLE   ? (acc ? ACC_HI : IDLE) :
          state == ACC_HI ? (r_dbl ? ACC_LO : WAIT) :
          state == ACC_LO ? WAIT :
          state == WAIT   ? RESP :
          (acc ? ACC_HI : IDLE);
  end

  // doubled data keeps the first dropped bit in h[0] for half-up rounding
  always_comb begin
    f = r_fmt == 3'd0 ? N_STO-1 : r_fmt == 3'd1 ? N_STO-2 :
        r_fmt == 3'd2 ? N_STO-5 : r_fmt == 3'd3 ? N_STO-6 : SW-10;
    sh = SHW'(Q_COMP - f);
    h = $signed({r_wdata[N_COMP-1], r_wdata, 1'b0}) >>> sh;
    rnd = h[N_COMP+1:1] + (N_COMP+1)'(h[0]);
    max_v = r_dbl ? {{(N_COMP+2-SW){1'b0}}, {(SW-1){1'b1}}}
                  : {{(N_COMP+2-N_STO){1'b0}}, {(N_STO-1){1'b1}}};
    min_v = ~max_v;
    ovf = rnd > max_v;
    unf = rnd < min_v;
    st = ovf ? max_v[SW-1:0] : unf ? min_v[SW-1:0] : rnd[SW-1:0];
    rx = r_dbl ? {{(N_COMP-SW){rd_hi[N_STO-1]}}, rd_hi, rd_lo}
               : {{(N_COMP-N_STO){rd_lo[N_STO-1]}}, rd_lo};
    rdata_c = rx << sh;
  end

  assign bank_en    = state == ACC_HI && !err ? N_BANKS'(1) << b_hi :
                      state == ACC_LO && !err ? N_BANKS'(1) << b_lo : '0;
  assign bank_wen   = r_write && !err && (state == ACC_HI || state == ACC_LO);
  assign bank_addr  = state == ACC_HI && !err ? w_hi : state == ACC_LO && !err ? w_lo : '0;
  assign bank_wdata = !bank_wen ? '0 : state == ACC_HI && r_dbl ? st[SW-1:N_STO] : st[N_STO-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      r_write <= 1'b0;
      r_dbl   <= 1'b0;
      r_addr  <= '0;
      r_fmt   <= '0;
      r_wdata <= '0;
      rd_hi   <= '0;
      rd_lo   <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        r_write <= req_write;
        r_dbl   <= req_width;
        r_addr  <= req_addr;
        r_fmt   <= req_format;
        r_wdata <= req_wdata;
      end
      if (state == ACC_LO) rd_hi <= bank_rdata[b_hi*N_STO +: N_STO];
      if (state == WAIT) rd_lo <= bank_rdata[(r_dbl ? b_lo : b_hi)*N_STO +: N_STO];
    end
  end

`ifdef INT_RES_MEM_SAT_STATS_EN
  logic [15:0] sat_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt <= '0;
    else if (state == WAIT && r_write && !err && (ovf || unf) && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 1'b1;
  end
  assign sat_count = sat_cnt;
`else
  assign sat_count = '0;
`endif
endmodule

// File: tb/tb_int_res_mem_ctrl.sv
// tb_int_res_mem_ctrl: directed checks of int_res_mem_ctrl against a behavioural SRAM model
module tb_int_res_mem_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, req_write = 0, req_width = 0;
  logic [15:0] req_addr = '0;
  logic [2:0]  req_format = '0;
  logic [38:0] req_wdata = '0;
  logic        rsp_valid, rsp_err, bank_wen;
  logic [38:0] rsp_rdata;
  logic [3:0]  bank_en;
  logic [13:0] bank_addr;
  logic [14:0] bank_wdata;
  logic [59:0] bank_rdata = '0;
  logic [15:0] sat_count;
  logic [14:0] mem [4][14336];
  logic [30:0] wr_q[$];
  int en_cnt = 0, ovl = 0, n_chk = 0, n_fail = 0;
`ifdef INT_RES_MEM_SAT_STATS_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif

  always #5 clk = ~clk;

  int_res_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_width(req_width),
    .req_format(req_format), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bank_en(bank_en), .bank_wen(bank_wen),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .sat_count(sat_count)
  );

  always @(posedge clk) begin
    if ($countones(bank_en) > 1) ovl <= ovl + 1;
    if (bank_en != 0) en_cnt <= en_cnt + 1;
    for (int b = 0; b < 4; b++)
      if (bank_en[b]) begin
        bank_rdata[b*15 +: 15] <= mem[b][bank_addr];
        if (bank_wen) begin
          mem[b][bank_addr] <= bank_wdata;
          wr_q.push_back({2'(b), bank_addr, bank_wdata});
        end
      end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] ent(input int b, input int a, input int d);
    return {2'(b), 14'(a), 15'(d)};
  endfunction

  task automatic do_req(input logic w, input logic [15:0] a, input logic dbl, input logic [2:0] fm,
                        input logic [38:0] wd, output int lat, output logic [38:0] rd, output logic er);
    @(negedge clk);
    req_write = w; req_addr = a; req_width = dbl; req_format = fm; req_wdata = wd; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  initial begin
    int lat, e0, seen;
    logic [38:0] rd;
    logic er;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_outs", {rsp_valid, rsp_err, bank_en, bank_wen}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_bank", {bank_addr, bank_wdata}, 0);
    chk("rst_sat", sat_count, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", req_ready, 1);

    wr_q.delete();
    do_req(1, 100, 0, 2, 39'h300000, lat, rd, er);
    chk("w15_lat", lat, 3);
    chk("w15_n", wr_q.size(), 1);
    chk("w15_data", wr_q[0], ent(0, 100, 'h600));
    chk("w15_err", er, 0);
    do_req(0, 100, 0, 2, '0, lat, rd, er);
    chk("r15_lat", lat, 3);
    chk("r15_data", rd, 39'h300000);
    chk("r15_err", er, 0);

    wr_q.delete();
    do_req(1, 102, 0, 2, 39'h300400, lat, rd, er);
    chk("wrnd_data", wr_q[0], ent(0, 102, 'h601));
    do_req(0, 102, 0, 2, '0, lat, rd, er);
    chk("rrnd_data", rd, 39'h300800);
    wr_q.delete();
    do_req(1, 103, 0, 2, 39'h7FFFFFFC00, lat, rd, er);
    chk("wneg_rnd", wr_q[0], ent(0, 103, 0));

    wr_q.delete();
    do_req(1, 104, 0, 2, 39'hC800000, lat, rd, er);
    chk("wsatp_data", wr_q[0], ent(0, 104, 'h3FFF));
    chk("wsatp_cnt", sat_count, SE);
    wr_q.delete();
    do_req(1, 105, 0, 2, 39'h7FF3800000, lat, rd, er);
    chk("wsatn_data", wr_q[0], ent(0, 105, 'h4000));
    chk("wsatn_cnt", sat_count, 2*SE);
    do_req(0, 104, 0, 2, '0, lat, rd, er);
    chk("rsatp_data", rd, 39'h1FFF800);

    wr_q.delete();
    do_req(1, 106, 0, 0, 39'h100000, lat, rd, er);
    chk("wf1_data", wr_q[0], ent(0, 106, 'h2000));
    do_req(0, 106, 0, 0, '0, lat, rd, er);
    chk("rf1_data", rd, 39'h100000);

    wr_q.delete();
    do_req(1, 14335, 1, 4, 39'h7FFFB80000, lat, rd, er);
    chk("wdw_lat", lat, 4);
    chk("wdw_n", wr_q.size(), 2);
    chk("wdw_hi", wr_q[0], ent(0, 14335, 'h7FB8));
    chk("wdw_lo", wr_q[1], ent(1, 0, 0));
    do_req(0, 14335, 1, 4, '0, lat, rd, er);
    chk("rdw_lat", lat, 4);
    chk("rdw_data", rd, 39'h7FFFB80000);
    chk("rdw_err", er, 0);
    wr_q.delete();
    do_req(1, 200, 1, 4, 39'h123456, lat, rd, er);
    chk("wdw2_hi", wr_q[0], ent(0, 200, 'h12));
    chk("wdw2_lo", wr_q[1], ent(0, 201, 'h1A2B));
    do_req(0, 200, 1, 4, '0, lat, rd, er);
    chk("rdw2_data", rd, 39'h123456);

    e0 = en_cnt;
    do_req(0, 57344, 0, 2, '0, lat, rd, er);
    chk("err1_lat", lat, 3);
    chk("err1_err", er, 1);
    chk("err1_rdata", rd, 0);
    chk("err1_en", en_cnt - e0, 0);
    e0 = en_cnt;
    do_req(0, 57343, 1, 4, '0, lat, rd, er);
    chk("err2_lat", lat, 4);
    chk("err2_err", er, 1);
    chk("err2_rdata", rd, 0);
    chk("err2_en", en_cnt - e0, 0);

    @(negedge clk);
    req_write = 1; req_addr = 300; req_width = 0; req_format = 2; req_wdata = 39'h300000; req_valid = 1;
    @(posedge clk); #1;
    chk("b2b_ready_low", req_ready, 0);
    req_write = 0; req_wdata = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat1", lat, 3);
    chk("b2b_ready_rsp", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat2", lat, 3);
    chk("b2b_rdata", rd, rd);
    chk("b2b_rdata2", rsp_rdata, 39'h300000);
    chk("no_overlap", ovl, 0);

    do_req(0, 300, 0, 2, '0, lat, rd, er);
    @(negedge clk);
    req_write = 1; req_addr = 500; req_width = 1; req_format = 4; req_wdata = 39'h123456; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rl_en_hi", bank_en, 4'b0001);
    @(posedge clk); #1;
    chk("rl_addr_lo", bank_addr, 501);
    rst_n = 0;
    #1;
    chk("rl_strobes", {bank_en, bank_wen}, 0);
    chk("rl_bank", {bank_addr, bank_wdata}, 0);
    chk("rl_rsp", {rsp_valid, rsp_err}, 0);
    chk("rl_ready", req_ready, 1);
    chk("rl_sat", sat_count, 0);
    @(negedge clk) rst_n = 1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("rl_no_rsp", seen, 0);
    chk("rl_ready_after", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
